// File: rtl/captura_jogada_pkg.sv
// Shared definitions for the play-capture block: FSM state codes and
// the debounce lengths used for the real board and for simulation.
package captura_jogada_pkg;

  // 1 ms at 50 MHz on the board; a short filter keeps simulations fast
  localparam int DEBOUNCE_SINTESE = 50000;
  localparam int DEBOUNCE_SIM     = 4;

  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    FILTRA_PRESSAO  = 3'd1,
    AVALIA          = 3'd2,
    REGISTRA        = 3'd3,
    AGUARDA_SOLTURA = 3'd4,
    FILTRA_SOLTURA  = 3'd5,
    INVALIDA        = 3'd6
  } estado_t;

endpackage

// File: rtl/captura_jogada_sincronizador_2ff.sv
// Two-flop synchronizer bringing asynchronous levels into the clock domain.
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/captura_jogada.sv
// Turns raw push-buttons into clean single-cycle play events: synchronize,
// debounce the press, accept only one-hot codes, then debounce the release.
module captura_jogada
  import captura_jogada_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_SINTESE,
  parameter int W_CONT          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic                zera,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada_feita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_invalida,
  output logic                db_tem_jogada,
  output logic [3:0]          db_estado
);

  localparam logic [W_CONT-1:0] CONT_FIM = W_CONT'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] b_sync;
  logic [N_BOTOES-1:0] b_amostra;
  logic [N_BOTOES-1:0] jogada_reg;
  logic [W_CONT-1:0]   cont;
  logic                carrega;
  logic                conta;
  estado_t             estado;
  estado_t             proximo;

  sincronizador_2ff #(.WIDTH(N_BOTOES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (b_sync)
  );

  // Sample register plus saturating stability counter; a fresh sample restarts the count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_amostra <= '0;
      cont      <= '0;
    end else if (carrega) begin
      b_amostra <= b_sync;
      cont      <= '0;
    end else if (conta && (cont != '1)) begin
      cont <= cont + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic and sample/counter control; abort paths take priority over the count
  always_comb begin
    proximo = estado;
    carrega = 1'b0;
    conta   = 1'b0;
    case (estado)
      OCIOSO: begin
        if ((b_sync != '0) && habilita) begin
          proximo = FILTRA_PRESSAO;
          carrega = 1'b1;
        end
      end
      FILTRA_PRESSAO: begin
        conta = 1'b1;
        if ((b_sync == '0) || !habilita) begin
          proximo = OCIOSO;
        end else if (b_sync != b_amostra) begin
          carrega = 1'b1;
        end else if (cont == CONT_FIM) begin
          proximo = AVALIA;
        end
      end
      AVALIA: begin
        proximo = $onehot(b_amostra) ? REGISTRA : INVALIDA;
      end
      REGISTRA: begin
        proximo = AGUARDA_SOLTURA;
      end
      INVALIDA: begin
        proximo = AGUARDA_SOLTURA;
      end
      AGUARDA_SOLTURA: begin
        if (b_sync == '0) begin
          proximo = FILTRA_SOLTURA;
          carrega = 1'b1;
        end
      end
      FILTRA_SOLTURA: begin
        conta = 1'b1;
        if (b_sync != '0) begin
          proximo = AGUARDA_SOLTURA;
          carrega = 1'b1;
        end else if (cont == CONT_FIM) begin
          proximo = OCIOSO;
        end
      end
      default: begin
        proximo = OCIOSO;
      end
    endcase
  end

  // Play register: loads on the edge leaving REGISTRA, which also beats a simultaneous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada_reg <= '0;
    end else if (estado == REGISTRA) begin
      jogada_reg <= b_amostra;
    end else if (zera) begin
      jogada_reg <= '0;
    end
  end

  // During REGISTRA the sample is shown directly so the pulse and its code appear together
  always_comb begin
    jogada_feita    = (estado == REGISTRA);
    jogada_invalida = (estado == INVALIDA);
    jogada          = jogada_feita ? b_amostra : jogada_reg;
    db_tem_jogada   = |b_sync;
    db_estado       = {1'b0, estado};
  end

endmodule

// File: tb/tb_captura_jogada.sv
// Self-checking bench for captura_jogada: directed scenarios plus random
// button activity, compared each cycle against a history-based reference model.
module tb_captura_jogada;

  localparam int D = 4;
  localparam int HIST = 8192;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic       zera;
  logic [3:0] botoes;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       db_tem_jogada;
  logic [3:0] db_estado;

  captura_jogada #(
    .N_BOTOES        (4),
    .DEBOUNCE_CICLOS (D),
    .W_CONT          (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .zera            (zera),
    .botoes          (botoes),
    .jogada_feita    (jogada_feita),
    .jogada          (jogada),
    .jogada_invalida (jogada_invalida),
    .db_tem_jogada   (db_tem_jogada),
    .db_estado       (db_estado)
  );

  // Free-running 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: input history, press/release windows and the scheduled event
  logic [3:0] bot_h [0:HIST-1];
  bit         hab_h [0:HIST-1];
  int         cyc;
  bit         locked;
  int         armed_from;
  int         release_from;
  int         ev_cycle;
  logic [3:0] ev_code;
  logic [3:0] jreg;

  // Per-phase observation counters
  int cnt_feita;
  int cnt_inv;
  int first_feita;
  int mark;
  int state_mask;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] bsync_at(input int k);
    if (k < 2) return 4'b0000;
    return bot_h[k-2];
  endfunction

  task automatic model_init();
    cyc          = 0;
    locked       = 1'b0;
    armed_from   = 0;
    release_from = 0;
    ev_cycle     = -1;
    ev_code      = 4'b0000;
    jreg         = 4'b0000;
  endtask

  task automatic mark_phase();
    cnt_feita   = 0;
    cnt_inv     = 0;
    first_feita = -1;
    mark        = cyc;
    state_mask  = 0;
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model
  task automatic apply_stimulus(input logic [3:0] b, input logic h, input logic z);
    logic [3:0] bs;
    logic [3:0] v;
    logic [3:0] exp_j;
    logic       exp_f;
    logic       exp_i;
    bit         ok;
    if (cyc >= HIST - 1) begin
      $display("[TB] FAIL history_overflow: got %0d, expected below %0d", cyc, HIST - 1);
      $fatal(1, "[TB] history overflow");
    end
    bs    = bsync_at(cyc);
    exp_f = (ev_cycle == cyc) && $onehot(ev_code);
    exp_i = (ev_cycle == cyc) && !$onehot(ev_code);
    exp_j = exp_f ? ev_code : jreg;
    check_output("jogada_feita", 32'(jogada_feita), 32'(exp_f));
    check_output("jogada_invalida", 32'(jogada_invalida), 32'(exp_i));
    check_output("jogada", 32'(jogada), 32'(exp_j));
    check_output("db_tem_jogada", 32'(db_tem_jogada), 32'(|bs));
    if (jogada_feita) begin
      cnt_feita++;
      if (first_feita < 0) first_feita = cyc - mark;
    end
    if (jogada_invalida) cnt_inv++;
    state_mask = state_mask | (1 << db_estado);

    botoes   = b;
    habilita = h;
    zera     = z;
    bot_h[cyc] = b;
    hab_h[cyc] = h;

    if (!locked && (cyc - D >= armed_from)) begin
      v  = bsync_at(cyc);
      ok = (v != 4'b0000);
      for (int i = cyc - D; i <= cyc; i++) begin
        if ((bsync_at(i) != v) || !hab_h[i]) ok = 1'b0;
      end
      if (ok) begin
        locked       = 1'b1;
        ev_cycle     = cyc + 2;
        ev_code      = v;
        release_from = cyc + 3;
      end
    end else if (locked && (cyc - D >= release_from)) begin
      ok = 1'b1;
      for (int i = cyc - D; i <= cyc; i++) begin
        if (bsync_at(i) != 4'b0000) ok = 1'b0;
      end
      if (ok) begin
        locked     = 1'b0;
        armed_from = cyc + 1;
      end
    end

    if (exp_f) jreg = ev_code;
    else if (z) jreg = 4'b0000;

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    botoes   = 4'b0000;
    habilita = 1'b0;
    zera     = 1'b0;
    #1;
    check_output("reset_feita", 32'(jogada_feita), 32'd0);
    check_output("reset_invalida", 32'(jogada_invalida), 32'd0);
    check_output("reset_jogada", 32'(jogada), 32'd0);
    check_output("reset_tem_jogada", 32'(db_tem_jogada), 32'd0);
    check_output("reset_estado", 32'(db_estado), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    model_init();
  endtask

  task automatic release_buttons();
    repeat (10) apply_stimulus(4'b0000, 1'b1, 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] val;
    int         len;
    logic       hb;
    reset    = 1'b1;
    habilita = 1'b0;
    zera     = 1'b0;
    botoes   = 4'b0000;
    cyc      = 0;
    #2;
    do_reset();
    mark_phase();

    $display("[TB] reset and idle");
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(4'b0000, 1'b1, 1'b0);
      check_output("idle_estado", 32'(db_estado), 32'd0);
    end

    $display("[TB] clean press");
    mark_phase();
    repeat (12) apply_stimulus(4'b0100, 1'b1, 1'b0);
    check_output("limpa_pulsos", 32'(cnt_feita), 32'd1);
    check_output("limpa_atraso", 32'(first_feita), 32'd8);
    check_output("limpa_jogada", 32'(jogada), 32'h4);
    check_output("limpa_estados", 32'(state_mask), 32'h1F);
    release_buttons();
    check_output("limpa_soltura", 32'(db_estado), 32'd0);

    $display("[TB] bounce");
    mark_phase();
    apply_stimulus(4'b0001, 1'b1, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    apply_stimulus(4'b0001, 1'b1, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    repeat (12) apply_stimulus(4'b0001, 1'b1, 1'b0);
    check_output("bounce_pulsos", 32'(cnt_feita), 32'd1);
    check_output("bounce_atraso", 32'(first_feita), 32'd12);
    check_output("bounce_jogada", 32'(jogada), 32'h1);
    release_buttons();

    $display("[TB] two buttons");
    mark_phase();
    repeat (12) apply_stimulus(4'b0011, 1'b1, 1'b0);
    check_output("dois_invalida", 32'(cnt_inv), 32'd1);
    check_output("dois_feita", 32'(cnt_feita), 32'd0);
    check_output("dois_jogada", 32'(jogada), 32'h1);
    release_buttons();

    $display("[TB] habilita low");
    mark_phase();
    repeat (12) apply_stimulus(4'b1000, 1'b0, 1'b0);
    check_output("hab0_feita", 32'(cnt_feita), 32'd0);
    check_output("hab0_invalida", 32'(cnt_inv), 32'd0);
    check_output("hab0_estados", 32'(state_mask), 32'h1);
    mark_phase();
    repeat (12) apply_stimulus(4'b1000, 1'b1, 1'b0);
    check_output("hab1_feita", 32'(cnt_feita), 32'd1);
    check_output("hab1_jogada", 32'(jogada), 32'h8);
    release_buttons();

    $display("[TB] zera collision");
    mark_phase();
    repeat (8) apply_stimulus(4'b0010, 1'b1, 1'b0);
    apply_stimulus(4'b0010, 1'b1, 1'b1);
    check_output("zera_reg_feita", 32'(cnt_feita), 32'd1);
    check_output("zera_reg_jogada", 32'(jogada), 32'h2);
    repeat (3) apply_stimulus(4'b0010, 1'b1, 1'b0);
    release_buttons();
    mark_phase();
    repeat (9) apply_stimulus(4'b0001, 1'b1, 1'b0);
    apply_stimulus(4'b0001, 1'b1, 1'b1);
    check_output("zera_apos_feita", 32'(cnt_feita), 32'd1);
    check_output("zera_apos_jogada", 32'(jogada), 32'h0);
    release_buttons();

    $display("[TB] reset mid-filter");
    mark_phase();
    repeat (4) apply_stimulus(4'b0100, 1'b1, 1'b0);
    check_output("filtro_estado", 32'(db_estado), 32'd1);
    do_reset();
    repeat (10) apply_stimulus(4'b0000, 1'b1, 1'b0);
    check_output("pos_reset_feita", 32'(cnt_feita), 32'd0);
    check_output("pos_reset_estado", 32'(db_estado), 32'd0);

    $display("[TB] random activity");
    for (int s = 0; s < 200; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: val = 4'b0000;
        8, 9:    val = 4'($urandom_range(1, 15));
        default: val = 4'(1 << $urandom_range(0, 3));
      endcase
      len = $urandom_range(1, 12);
      hb  = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < len; k++) begin
        apply_stimulus(val, hb, ($urandom_range(0, 15) == 0));
      end
    end
    release_buttons();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
